coprocessor_controller: RTL and testbench
=========================================

COPROCESSOR_CONTROLLER -- requirements
Module: coprocessor_controller

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter A_BASE, default 0, first byte address of matrix A.
REQ-003 Parameter B_BASE, default 25, first byte address of matrix B.
REQ-004 Parameter C_BASE, default 50, first byte address of result C.
REQ-005 clock  in  1  single clock; all state SHALL change on posedge only.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  high only in IDLE.
REQ-009 cmd_opcode  in  3  ALU opcode to execute.
REQ-010 cmd_scalar  in  8  scalar for opcode 3'b110.
REQ-011 mem_addr  out  ADDR_W  byte address for read or write.
REQ-012 mem_rd_en  out  1  read strobe; mem_rdata valid exactly one cycle later.
REQ-013 mem_rdata  in  8  read data.
REQ-014 mem_wr_en, mem_wdata  out  1, 8  write strobe and data.
REQ-015 alu_A_flat, alu_B_flat  out  200, 200  operand registers; element k in bits [8k+7:8k], k=0..24.
REQ-016 alu_f  out  8  registered scalar.
REQ-017 alu_opcode  out  3  ALU opcode; 3'b000 outside ISSUE and LATCH.
REQ-018 alu_C_flat, alu_overflow  in  200, 1  registered ALU result and overflow.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse at command completion.
REQ-021 overflow, error  out  1, 1  status, held from DONE until the next command accept.

Function
REQ-022 States SHALL be IDLE, LOAD_A, LOAD_B, CAPTURE, ISSUE, LATCH, STORE, DONE.
REQ-023 Accept SHALL occur when cmd_valid and cmd_ready are high at a posedge; the accept edge latches opcode and scalar, clears B, overflow, error and the byte counter.
REQ-024 Binary opcodes are 3'b001, 3'b010, 3'b011; unary opcodes are 3'b100, 3'b101, 3'b110; 3'b000 and 3'b111 are illegal.
REQ-025 For an illegal opcode: IDLE -> DONE; error=1; no mem_rd_en or mem_wr_en asserted.
REQ-026 LOAD_A SHALL last 25 cycles issuing reads at A_BASE+k, k=0..24; byte k is written into A element k on the edge after its read.
REQ-027 On the last LOAD_A cycle: binary -> LOAD_B; unary -> CAPTURE.
REQ-028 LOAD_B SHALL behave the same at B_BASE into B, then -> CAPTURE.
REQ-029 CAPTURE SHALL last 1 cycle and take the final read byte; alu_opcode=3'b000.
REQ-030 ISSUE SHALL last 1 cycle with alu_opcode=latched opcode and operands stable.
REQ-031 LATCH SHALL last 1 cycle with opcode held; at its end edge, C register <= alu_C_flat and overflow <= alu_overflow.
REQ-032 STORE SHALL last 25 cycles with mem_wr_en=1, mem_addr=C_BASE+k, mem_wdata=C element k; then -> DONE.
REQ-033 DONE SHALL last 1 cycle with done=1, then -> IDLE.
REQ-034 Latency from accept edge to done-high cycle SHALL be 79 cycles for binary, 54 for unary, 1 for illegal.
REQ-035 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.
REQ-036 Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not flagged.
REQ-037 cmd_valid while busy SHALL be ignored (not queued).

Reset
REQ-038 reset_n=0 at a posedge SHALL force IDLE and clear all outputs and registers to 0 (cmd_ready=1), including mid-operation; the partial STORE is not completed.

Verification
REQ-039 Add: A elements all 3, B elements all 4, opcode 001 -> 25 writes of 7 at 50..74; done at cycle 79; overflow=0.
REQ-040 Scalar: A all 100, scalar 2, opcode 110 -> no B reads; overflow=1 latched; done at cycle 54.
REQ-041 Transpose: A element k = k, opcode 101 -> C_BASE+(5r+c) holds 5c+r.
REQ-042 Illegal: opcode 111 -> done next cycle, error=1, zero memory strobes.
REQ-043 reset_n low during STORE byte 10 -> next cycle IDLE, mem_wr_en=0, cmd_ready=1; a new command then runs normally.
REQ-044 cmd_valid held high through a whole command -> exactly one accept per IDLE visit, back-to-back commands with a 1-cycle IDLE gap.

Source files
------------

// File: rtl/coprocessor_controller_if.sv
// Command, memory and ALU signal bundle for coprocessor_controller.
// slave: the controller side; master: the environment (command source, memory, ALU).
interface coprocessor_controller_if #(
   parameter int ADDR_W = 8
);
   // command handshake
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_opcode;
   logic [7:0]        cmd_scalar;
   // byte memory
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [7:0]        mem_rdata;
   logic              mem_wr_en;
   logic [7:0]        mem_wdata;
   // matrix ALU
   logic [199:0]      alu_A_flat;
   logic [199:0]      alu_B_flat;
   logic [7:0]        alu_f;
   logic [2:0]        alu_opcode;
   logic [199:0]      alu_C_flat;
   logic              alu_overflow;
   // status
   logic              busy;
   logic              done;
   logic              overflow;
   logic              error;

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_scalar, mem_rdata, alu_C_flat, alu_overflow,
      output cmd_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
             alu_A_flat, alu_B_flat, alu_f, alu_opcode, busy, done, overflow, error
   );

   modport master (
      output cmd_valid, cmd_opcode, cmd_scalar, mem_rdata, alu_C_flat, alu_overflow,
      input  cmd_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
             alu_A_flat, alu_B_flat, alu_f, alu_opcode, busy, done, overflow, error
   );
endinterface

// File: rtl/coprocessor_controller.sv
// Sequences a 5x5 byte-matrix ALU: loads A (and B for binary ops) from memory,
// issues the opcode, latches the result and stores C back to memory.
module coprocessor_controller #(
   parameter int ADDR_W = 8,
   parameter int A_BASE = 0,
   parameter int B_BASE = 25,
   parameter int C_BASE = 50
) (
   input  logic                     clock,
   input  logic                     reset_n,
   coprocessor_controller_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_B, CAPTURE, ISSUE, LATCH, STORE, DONE
   } state_t;

   localparam logic [ADDR_W-1:0] A_ADDR = ADDR_W'(A_BASE);
   localparam logic [ADDR_W-1:0] B_ADDR = ADDR_W'(B_BASE);
   localparam logic [ADDR_W-1:0] C_ADDR = ADDR_W'(C_BASE);
   localparam logic [4:0]        LAST   = 5'd24;

   state_t            r_state;
   logic [4:0]        r_cnt;
   logic [2:0]        r_op;
   logic [7:0]        r_f;
   logic [199:0]      r_A;
   logic [199:0]      r_B;
   logic [199:0]      r_C;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rd_en;
   logic              r_wr_en;
   logic [7:0]        r_wdata;
   logic [2:0]        r_alu_op;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_ovf;
   logic              r_err;
   // read-return pipeline: data for a read arrives the cycle after its strobe
   logic              r_cap_en;
   logic              r_cap_b;
   logic [4:0]        r_cap_idx;

   logic              w_accept;
   logic              w_binary;
   logic              w_legal;
   logic [4:0]        w_next_cnt;

   assign w_accept   = bus.cmd_valid && r_ready;
   assign w_binary   = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b011);
   assign w_legal    = (bus.cmd_opcode != 3'b000) && (bus.cmd_opcode != 3'b111);
   assign w_next_cnt = r_cnt + 5'd1;

   // Single FSM: state, counters, operand/result registers and all registered outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_f       <= '0;
         r_A       <= '0;
         r_B       <= '0;
         r_C       <= '0;
         r_addr    <= '0;
         r_rd_en   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wdata   <= '0;
         r_alu_op  <= '0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
         r_cap_en  <= 1'b0;
         r_cap_b   <= 1'b0;
         r_cap_idx <= '0;
      end else begin
         r_cap_en  <= r_rd_en;
         r_cap_b   <= (r_state == LOAD_B);
         r_cap_idx <= r_cnt;
         if (r_cap_en) begin
            if (r_cap_b) r_B[{r_cap_idx, 3'b000} +: 8] <= bus.mem_rdata;
            else         r_A[{r_cap_idx, 3'b000} +: 8] <= bus.mem_rdata;
         end

         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op    <= bus.cmd_opcode;
                  r_f     <= bus.cmd_scalar;
                  r_B     <= '0;
                  r_ovf   <= 1'b0;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  if (w_legal) begin
                     r_err   <= 1'b0;
                     r_state <= LOAD_A;
                     r_rd_en <= 1'b1;
                     r_addr  <= A_ADDR;
                  end else begin
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            LOAD_A, LOAD_B: begin
               if (r_cnt == LAST) begin
                  r_cnt <= '0;
                  if (r_state == LOAD_A && w_binary) begin
                     r_state <= LOAD_B;
                     r_addr  <= B_ADDR;
                  end else begin
                     r_state <= CAPTURE;
                     r_rd_en <= 1'b0;
                     r_addr  <= '0;
                  end
               end else begin
                  r_cnt  <= w_next_cnt;
                  r_addr <= r_addr + ADDR_W'(1);
               end
            end
            CAPTURE: begin
               r_state  <= ISSUE;
               r_alu_op <= r_op;
            end
            ISSUE: begin
               r_state <= LATCH;
            end
            LATCH: begin
               // byte 0 of the store comes straight from the ALU result port
               r_alu_op <= '0;
               r_C      <= bus.alu_C_flat;
               r_ovf    <= bus.alu_overflow;
               r_state  <= STORE;
               r_wr_en  <= 1'b1;
               r_addr   <= C_ADDR;
               r_wdata  <= bus.alu_C_flat[7:0];
               r_cnt    <= '0;
            end
            STORE: begin
               if (r_cnt == LAST) begin
                  r_state <= DONE;
                  r_wr_en <= 1'b0;
                  r_addr  <= '0;
                  r_wdata <= '0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= w_next_cnt;
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_wdata <= r_C[{w_next_cnt, 3'b000} +: 8];
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = r_ready;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_rd_en  = r_rd_en;
   assign bus.mem_wr_en  = r_wr_en;
   assign bus.mem_wdata  = r_wdata;
   assign bus.alu_A_flat = r_A;
   assign bus.alu_B_flat = r_B;
   assign bus.alu_f      = r_f;
   assign bus.alu_opcode = r_alu_op;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.overflow   = r_ovf;
   assign bus.error      = r_err;

endmodule

// File: tb/tb_coprocessor_controller.sv
// Directed bench for coprocessor_controller with a byte memory and a matrix ALU model.
module tb_coprocessor_controller;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   coprocessor_controller_if #(.ADDR_W(8)) bus ();

   coprocessor_controller #(
      .ADDR_W(8), .A_BASE(0), .B_BASE(25), .C_BASE(50)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [7:0] rmem [0:255];
   logic [7:0] wmem [0:255];

   // monitor totals (single writer)
   int cyc = 0, acc_n = 0, last_acc = 0, done_n = 0, done_cyc = 0;
   int rd_n = 0, rdb_n = 0, wr_n = 0, both_n = 0;
   int acc_cyc [0:31];

   // ALU reference: 001 add, 010 sub, 011 and, 100 invert, 101 transpose, 110 scalar multiply
   function automatic logic [200:0] alu_model(input logic [2:0] op, input logic [199:0] a,
                                              input logic [199:0] b, input logic [7:0] f);
      logic [199:0] c;
      logic ov;
      logic [7:0] ea, eb;
      logic [8:0] s;
      logic [15:0] p;
      c = '0; ov = 1'b0;
      for (int k = 0; k < 25; k++) begin
         ea = a[8*k +: 8];
         eb = b[8*k +: 8];
         case (op)
            3'b001: begin s = 9'(ea) + 9'(eb); c[8*k +: 8] = s[7:0]; ov = ov | s[8]; end
            3'b010: begin c[8*k +: 8] = ea - eb; ov = ov | (ea < eb); end
            3'b011: c[8*k +: 8] = ea & eb;
            3'b100: c[8*k +: 8] = ~ea;
            3'b101: c[8*k +: 8] = a[8*(5*(k%5) + k/5) +: 8];
            3'b110: begin p = 16'(ea) * 16'(f); c[8*k +: 8] = p[7:0]; ov = ov | (p > 16'd127); end
            default: c[8*k +: 8] = 8'h00;
         endcase
      end
      return {ov, c};
   endfunction

   logic [200:0] alu_res;

   // registered ALU: result valid the cycle after an opcode is presented
   always @(posedge clock) begin
      if (bus.alu_opcode != 3'b000) begin
         alu_res = alu_model(bus.alu_opcode, bus.alu_A_flat, bus.alu_B_flat, bus.alu_f);
         bus.alu_C_flat   <= alu_res[199:0];
         bus.alu_overflow <= alu_res[200];
      end
   end

   // memory: read data returned one cycle after the strobe
   always @(posedge clock) begin
      if (bus.mem_rd_en) bus.mem_rdata <= rmem[bus.mem_addr];
      if (bus.mem_wr_en) wmem[bus.mem_addr] <= bus.mem_wdata;
   end

   // strobe and handshake monitor
   always @(posedge clock) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
         if (acc_n < 32) acc_cyc[acc_n] = cyc;
         acc_n = acc_n + 1;
         last_acc = cyc;
      end
      if (bus.done) begin done_n = done_n + 1; done_cyc = cyc; end
      if (bus.mem_rd_en) begin
         rd_n = rd_n + 1;
         if (bus.mem_addr >= 8'd25 && bus.mem_addr <= 8'd49) rdb_n = rdb_n + 1;
      end
      if (bus.mem_wr_en) wr_n = wr_n + 1;
      if (bus.mem_rd_en && bus.mem_wr_en) both_n = both_n + 1;
      cyc = cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic issue(input logic [2:0] op, input logic [7:0] sc);
      @(negedge clock);
      bus.cmd_valid  = 1'b1;
      bus.cmd_opcode = op;
      bus.cmd_scalar = sc;
      @(negedge clock);
      bus.cmd_valid  = 1'b0;
   endtask

   task automatic wait_done(input int base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (done_n > base) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if ({bus.mem_rd_en, bus.mem_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {bus.mem_rd_en, bus.mem_wr_en}); end
      checks++; if (bus.alu_opcode !== 3'b000) begin errors++; $display("FAIL reset_alu_opcode: got %b want 000", bus.alu_opcode); end
      checks++; if ({bus.overflow, bus.error} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want 00", {bus.overflow, bus.error}); end
      checks++; if (bus.mem_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.mem_addr); end
   endtask

   task automatic test_add;
      int d0, r0, w0, b0, bad;
      bit ok;
      for (int k = 0; k < 25; k++) begin rmem[k] = 8'd3; rmem[25+k] = 8'd4; end
      d0 = done_n; r0 = rd_n; w0 = wr_n; b0 = both_n;
      issue(3'b001, 8'd0);
      wait_done(d0, ok);
      bad = 0;
      for (int k = 0; k < 25; k++) if (wmem[50+k] !== 8'd7) bad++;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_done_seen: got %b want 1", ok); end
      checks++; if (done_cyc - last_acc != 79) begin errors++; $display("FAIL add_latency: got %0d want 79", done_cyc - last_acc); end
      checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL add_done_pulses: got %0d want 1", done_n - d0); end
      checks++; if (rd_n - r0 != 50) begin errors++; $display("FAIL add_reads: got %0d want 50", rd_n - r0); end
      checks++; if (wr_n - w0 != 25) begin errors++; $display("FAIL add_writes: got %0d want 25", wr_n - w0); end
      checks++; if (bad != 0) begin errors++; $display("FAIL add_result: got %0d wrong bytes (C[0]=%0d) want 0 (all 7)", bad, wmem[50]); end
      checks++; if ({bus.overflow, bus.error} !== 2'b00) begin errors++; $display("FAIL add_status: got %b want 00", {bus.overflow, bus.error}); end
      checks++; if (both_n - b0 != 0) begin errors++; $display("FAIL add_rd_wr_overlap: got %0d want 0", both_n - b0); end
      checks++; if ({bus.cmd_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL add_idle_after: got %b want 10", {bus.cmd_ready, bus.busy}); end
   endtask

   task automatic test_scalar;
      int d0, r0, rb0;
      bit ok;
      for (int k = 0; k < 25; k++) rmem[k] = 8'd100;
      d0 = done_n; r0 = rd_n; rb0 = rdb_n;
      issue(3'b110, 8'd2);
      wait_done(d0, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL scalar_done_seen: got %b want 1", ok); end
      checks++; if (done_cyc - last_acc != 54) begin errors++; $display("FAIL scalar_latency: got %0d want 54", done_cyc - last_acc); end
      checks++; if (rd_n - r0 != 25) begin errors++; $display("FAIL scalar_reads: got %0d want 25", rd_n - r0); end
      checks++; if (rdb_n - rb0 != 0) begin errors++; $display("FAIL scalar_b_reads: got %0d want 0", rdb_n - rb0); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL scalar_overflow: got %b want 1", bus.overflow); end
      checks++; if (wmem[74] !== 8'd200) begin errors++; $display("FAIL scalar_result: got %0d want 200", wmem[74]); end
      checks++; if (bus.alu_f !== 8'd2) begin errors++; $display("FAIL scalar_alu_f: got %0d want 2", bus.alu_f); end
   endtask

   task automatic test_transpose;
      int d0, bad;
      bit ok;
      for (int k = 0; k < 25; k++) rmem[k] = 8'(k);
      d0 = done_n;
      issue(3'b101, 8'd0);
      wait_done(d0, ok);
      bad = 0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            if (wmem[50 + 5*r + c] !== 8'(5*c + r)) bad++;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL transpose_done_seen: got %b want 1", ok); end
      checks++; if (bad != 0) begin errors++; $display("FAIL transpose_result: got %0d wrong bytes (C[1]=%0d) want 0 (C[1]=5)", bad, wmem[51]); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL transpose_overflow: got %b want 0", bus.overflow); end
   endtask

   task automatic test_illegal;
      int d0, r0, w0;
      bit ok;
      d0 = done_n; r0 = rd_n; w0 = wr_n;
      issue(3'b111, 8'd0);
      wait_done(d0, ok);
      checks++; if (done_cyc - last_acc != 1) begin errors++; $display("FAIL illegal111_latency: got %0d want 1", done_cyc - last_acc); end
      checks++; if ({bus.error, bus.overflow} !== 2'b10) begin errors++; $display("FAIL illegal111_status: got %b want 10", {bus.error, bus.overflow}); end
      checks++; if ((rd_n - r0) + (wr_n - w0) != 0) begin errors++; $display("FAIL illegal111_strobes: got %0d want 0", (rd_n - r0) + (wr_n - w0)); end
      d0 = done_n;
      issue(3'b000, 8'd0);
      wait_done(d0, ok);
      checks++; if (done_cyc - last_acc != 1) begin errors++; $display("FAIL illegal000_latency: got %0d want 1", done_cyc - last_acc); end
      checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL illegal000_error: got %b want 1", bus.error); end
      checks++; if ((rd_n - r0) + (wr_n - w0) != 0) begin errors++; $display("FAIL illegal000_strobes: got %0d want 0", (rd_n - r0) + (wr_n - w0)); end
   endtask

   task automatic test_reset_mid;
      int d0, w0;
      bit found, ok;
      for (int k = 0; k < 25; k++) begin rmem[k] = 8'd3; rmem[25+k] = 8'd4; end
      w0 = wr_n;
      issue(3'b001, 8'd0);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.mem_wr_en && bus.mem_addr == 8'd60) begin found = 1'b1; break; end
         @(negedge clock);
      end
      reset_n = 1'b0;
      @(negedge clock);
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_store10_seen: got %b want 1", found); end
      checks++; if ({bus.cmd_ready, bus.busy, bus.mem_wr_en} !== 3'b100) begin errors++; $display("FAIL rstmid_idle: got %b want 100", {bus.cmd_ready, bus.busy, bus.mem_wr_en}); end
      checks++; if (bus.alu_A_flat !== 200'd0) begin errors++; $display("FAIL rstmid_a_cleared: got %h want 0", bus.alu_A_flat); end
      checks++; if (wr_n - w0 != 11) begin errors++; $display("FAIL rstmid_writes: got %0d want 11", wr_n - w0); end
      reset_n = 1'b1;
      @(negedge clock);
      d0 = done_n; w0 = wr_n;
      issue(3'b001, 8'd0);
      wait_done(d0, ok);
      checks++; if (done_cyc - last_acc != 79) begin errors++; $display("FAIL rstmid_rerun_latency: got %0d want 79", done_cyc - last_acc); end
      checks++; if (wr_n - w0 != 25) begin errors++; $display("FAIL rstmid_rerun_writes: got %0d want 25", wr_n - w0); end
   endtask

   task automatic test_back_to_back;
      int a0, d0;
      bit ok;
      for (int k = 0; k < 25; k++) rmem[k] = 8'(k);
      a0 = acc_n; d0 = done_n;
      @(negedge clock);
      bus.cmd_valid  = 1'b1;
      bus.cmd_opcode = 3'b101;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (acc_n - a0 >= 3) break;
      end
      bus.cmd_valid = 1'b0;
      wait_done(d0 + 2, ok);
      checks++; if (acc_n - a0 != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", acc_n - a0); end
      if (a0 + 2 < 32) begin
         checks++; if (acc_cyc[a0+1] - acc_cyc[a0] != 55) begin errors++; $display("FAIL b2b_gap1: got %0d want 55", acc_cyc[a0+1] - acc_cyc[a0]); end
         checks++; if (acc_cyc[a0+2] - acc_cyc[a0+1] != 55) begin errors++; $display("FAIL b2b_gap2: got %0d want 55", acc_cyc[a0+2] - acc_cyc[a0+1]); end
      end
      checks++; if (done_n - d0 != 3) begin errors++; $display("FAIL b2b_dones: got %0d want 3", done_n - d0); end
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_opcode = 3'b000;
      bus.cmd_scalar = 8'd0;
      for (int i = 0; i < 256; i++) rmem[i] = 8'd0;
      test_reset;
      test_add;
      test_scalar;
      test_transpose;
      test_illegal;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
